// File: rtl/led_bus_pkg.sv
// Shared encodings and defaults for the two-master LED bus arbiter.
package led_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  localparam logic [31:0] LED_ADDR_DEFAULT = 32'hFFFF_F060;
  localparam int          LED_W_DEFAULT    = 24;

  // Word-address match: the two byte-offset bits never take part.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
    return (addr & 32'hFFFF_FFFC) == (base & 32'hFFFF_FFFC);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_bus_arbiter.sv
// Arbitrates two bus masters onto a single memory-mapped LED register.
// Optional blink mask and phase divider are enabled with macro LED_BLINK_EN.
module led_bus_arbiter
  import led_bus_pkg::*;
#(
  parameter logic [31:0] LED_ADDR  = LED_ADDR_DEFAULT,
  parameter int          LED_W     = LED_W_DEFAULT
`ifdef LED_BLINK_EN
  ,
  parameter int          BLINK_DIV = 25_000_000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_ack,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_ack,
  output logic [31:0]      m1_rdata,
  output logic [LED_W-1:0] led
);

  state_t           state_reg;
  state_t           state_next;
  logic             grant_load;
  logic             arb_grant;
  logic             winner_reg;
  logic             last_reg;
  logic [LED_W-1:0] led_reg;
  logic [31:0]      rdata_reg;
  logic [31:0]      rd_word;
  logic             sel_we;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic             hit_led;
  logic             commit;

  rr_arb2 u_rr_arb2 (
    .req   ({m1_req, m0_req}),
    .last  (last_reg),
    .grant (arb_grant)
  );

  // Requesters hold their command stable until ack, so the winner's live inputs are used.
  always_comb begin
    sel_we    = winner_reg ? m1_we    : m0_we;
    sel_addr  = winner_reg ? m1_addr  : m0_addr;
    sel_wdata = winner_reg ? m1_wdata : m0_wdata;
  end

  assign hit_led = addr_hit(sel_addr, LED_ADDR);
  assign commit  = (state_reg == ST_GRANT);

  always_comb begin
    state_next = state_reg;
    grant_load = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          state_next = ST_GRANT;
          grant_load = 1'b1;
        end
      end
      ST_GRANT: state_next = ST_ACK;
      ST_ACK:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

`ifdef LED_BLINK_EN
  localparam logic [31:0] MASK_ADDR = LED_ADDR + 32'd4;
  logic             hit_mask;
  logic [LED_W-1:0] mask_reg;
  logic [31:0]      div_cnt_reg;
  logic             phase_reg;
  logic [LED_W-1:0] led_out_reg;

  assign hit_mask = addr_hit(sel_addr, MASK_ADDR);
`endif

  always_comb begin
    rd_word = '0;
    if (hit_led) begin
      rd_word[LED_W-1:0] = led_reg;
    end
`ifdef LED_BLINK_EN
    else if (hit_mask) begin
      rd_word[LED_W-1:0] = mask_reg;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      winner_reg <= 1'b0;
      last_reg   <= 1'b1;
      led_reg    <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_load) begin
        winner_reg <= arb_grant;
        last_reg   <= arb_grant;
      end
      // Read data is captured in GRANT so the ACK cycle shows the pre-write value.
      if (commit) begin
        rdata_reg <= sel_we ? 32'd0 : rd_word;
        if (sel_we && hit_led) begin
          led_reg <= LED_W'(sel_wdata);
        end
      end
    end
  end

`ifdef LED_BLINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_reg    <= '0;
      div_cnt_reg <= '0;
      phase_reg   <= 1'b0;
      led_out_reg <= '0;
    end else begin
      if (commit && sel_we && hit_mask) begin
        mask_reg <= LED_W'(sel_wdata);
      end
      if (div_cnt_reg == 32'(BLINK_DIV - 1)) begin
        div_cnt_reg <= '0;
        phase_reg   <= ~phase_reg;
      end else begin
        div_cnt_reg <= div_cnt_reg + 32'd1;
      end
      led_out_reg <= led_reg ^ (mask_reg & {LED_W{phase_reg}});
    end
  end

  assign led = led_out_reg;
`else
  assign led = led_reg;
`endif

  assign m0_ack   = (state_reg == ST_ACK) && !winner_reg;
  assign m1_ack   = (state_reg == ST_ACK) &&  winner_reg;
  assign m0_rdata = m0_ack ? rdata_reg : 32'd0;
  assign m1_rdata = m1_ack ? rdata_reg : 32'd0;

endmodule
